mux_n_to_1_scan_reg: RTL and testbench

- Parametrised, registered N-channel, W-bit-wide multiplexer. It generalises the team's 1-bit 2:1 combinational mux.
- Two modes:
  - Manual: the channel comes from the select input, as in the 2:1 mux.
  - Scan: the block steps through all channels itself, holding each for a programmable number of cycles.
- Feeds display/readout logic that must observe several data sources over one shared bus.
- Output, current channel, valid and error flags are all registered.

---
 rtl/mux_n_to_1_scan_reg.sv | 98 +++++++++
 tb/tb_mux_n_to_1_scan_reg.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_n_to_1_scan_reg.sv
// Registered N-channel, W-bit multiplexer with manual select and self-stepping scan mode.
// All outputs are registered; en=0 freezes every piece of state.
module mux_n_to_1_scan_reg #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int DWELL    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      mode,
    input  logic                      en,
    output logic [WIDTH-1:0]          m,
    output logic [SEL_W-1:0]          ch,
    output logic                      valid,
    output logic                      sel_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic [SEL_W:0]   CH_LIM   = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] CH_LAST  = SEL_W'(CHANNELS - 1);
    localparam logic [7:0]       CNT_LAST = 8'(DWELL - 1);

    state_t           state;
    logic [7:0]       cnt;

    logic             sel_ok;
    logic             scan_adv;
    logic [SEL_W-1:0] scan_ch_next;
    logic [7:0]       scan_cnt_next;
    logic [SEL_W-1:0] mux_idx;
    logic [WIDTH-1:0] mux_data;

    // Entering SCAN from any other state always lands on channel 0 with a fresh count.
    always_comb begin
        sel_ok        = ({1'b0, sel} < CH_LIM);
        scan_adv      = (state == SCAN) && (cnt == CNT_LAST);
        scan_ch_next  = ch;
        scan_cnt_next = cnt + 8'd1;
        if (state != SCAN) begin
            scan_ch_next  = '0;
            scan_cnt_next = '0;
        end else if (scan_adv) begin
            scan_ch_next  = (ch == CH_LAST) ? '0 : ch + SEL_W'(1);
            scan_cnt_next = '0;
        end
    end

    always_comb begin
        mux_idx  = mode ? scan_ch_next : sel;
        mux_data = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (mux_idx == SEL_W'(k)) begin
                mux_data = data_in[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            m       <= '0;
            ch      <= '0;
            valid   <= 1'b0;
            sel_err <= 1'b0;
        end else if (en) begin
            valid <= 1'b1;
            if (mode) begin
                state   <= SCAN;
                cnt     <= scan_cnt_next;
                ch      <= scan_ch_next;
                m       <= mux_data;
                sel_err <= 1'b0;
            end else begin
                state <= MANUAL;
                cnt   <= '0;
                if (sel_ok) begin
                    m       <= mux_data;
                    ch      <= sel;
                    sel_err <= 1'b0;
                end else begin
                    m       <= '0;
                    ch      <= '0;
                    sel_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mux_n_to_1_scan_reg.sv
// Self-checking bench: table-driven manual vectors plus scan, freeze and async-reset sequences,
// with expectations queued at drive time and checked after each edge.
module tb_mux_n_to_1_scan_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    // 4-channel instance (defaults)
    logic [31:0] data_in;
    logic [1:0]  sel;
    logic        mode, en;
    logic [7:0]  m;
    logic [1:0]  ch;
    logic        valid, sel_err;
    // 3-channel, DWELL=1 instance
    logic [23:0] data3;
    logic [1:0]  sel3;
    logic        mode3, en3;
    logic [7:0]  m3;
    logic [1:0]  ch3;
    logic        valid3, err3;

    always #5 clk = ~clk;

    mux_n_to_1_scan_reg #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .DWELL(4)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .sel(sel), .mode(mode), .en(en),
        .m(m), .ch(ch), .valid(valid), .sel_err(sel_err)
    );

    mux_n_to_1_scan_reg #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .DWELL(1)) dut3 (
        .clk(clk), .rst_n(rst_n), .data_in(data3), .sel(sel3), .mode(mode3), .en(en3),
        .m(m3), .ch(ch3), .valid(valid3), .sel_err(err3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit         which;
        logic [7:0] m;
        logic [1:0] ch;
        logic       valid;
        logic       err;
        string      tag;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        bit          which;
        logic [1:0]  sel;
        logic        mode;
        logic        en;
        logic [31:0] data;
        logic [7:0]  m;
        logic [1:0]  ch;
        logic        valid;
        logic        err;
        string       tag;
    } vec_t;

    task automatic push_exp(input bit which, input logic [7:0] em, input logic [1:0] ech,
                            input logic ev, input logic ee, input string tag);
        exp_t e;
        e.which = which; e.m = em; e.ch = ech; e.valid = ev; e.err = ee; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic check_all();
        exp_t e;
        logic [7:0] am;
        logic [1:0] ach;
        logic av, ae;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty: got no queued expectation, required at least one");
            return;
        end
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            am  = e.which ? m3 : m;
            ach = e.which ? ch3 : ch;
            av  = e.which ? valid3 : valid;
            ae  = e.which ? err3 : sel_err;
            n_checks++;
            if ({am, ach, av, ae} !== {e.m, e.ch, e.valid, e.err}) begin
                n_fail++;
                $display("FAIL %s: got m=%h ch=%0d valid=%b sel_err=%b, required m=%h ch=%0d valid=%b sel_err=%b",
                         e.tag, am, ach, av, ae, e.m, e.ch, e.valid, e.err);
            end
        end
    endtask

    task automatic edge_check();
        @(posedge clk);
        #1;
        check_all();
    endtask

    function automatic logic [7:0] chan(input logic [31:0] d, input int k);
        return d[k*8 +: 8];
    endfunction

    vec_t vt[$];

    initial begin
        logic [31:0] d4;
        logic [31:0] d4b;
        logic [1:0]  ec;

        d4  = 32'h44332211;
        d4b = 32'h55667788;

        // Manual vectors: dut (which=0) then dut3 (which=1, channels 0x11,0x22,0x33)
        vt.push_back('{0, 2'd2, 1'b0, 1'b1, 32'h44332211, 8'h33, 2'd2, 1'b1, 1'b0, "man_sel2"});
        vt.push_back('{0, 2'd0, 1'b0, 1'b1, 32'h44332211, 8'h11, 2'd0, 1'b1, 1'b0, "man_sel0"});
        vt.push_back('{0, 2'd3, 1'b0, 1'b1, 32'h44332211, 8'h44, 2'd3, 1'b1, 1'b0, "man_sel3"});
        vt.push_back('{0, 2'd1, 1'b1, 1'b0, 32'h44332211, 8'h44, 2'd3, 1'b1, 1'b0, "man_freeze"});
        vt.push_back('{0, 2'd1, 1'b0, 1'b1, 32'hAABBCCDD, 8'hCC, 2'd1, 1'b1, 1'b0, "man_sel1_newdata"});
        vt.push_back('{1, 2'd3, 1'b0, 1'b1, 32'h00332211, 8'h00, 2'd0, 1'b1, 1'b1, "oor_sel3"});
        vt.push_back('{1, 2'd1, 1'b0, 1'b1, 32'h00332211, 8'h22, 2'd1, 1'b1, 1'b0, "oor_recover_sel1"});
        vt.push_back('{1, 2'd2, 1'b0, 1'b1, 32'h00332211, 8'h33, 2'd2, 1'b1, 1'b0, "c3_sel2_last"});
        vt.push_back('{1, 2'd3, 1'b1, 1'b1, 32'h00332211, 8'h11, 2'd0, 1'b1, 1'b0, "d1_scan_entry"});
        vt.push_back('{1, 2'd3, 1'b1, 1'b1, 32'h00332211, 8'h22, 2'd1, 1'b1, 1'b0, "d1_scan_ch1"});
        vt.push_back('{1, 2'd3, 1'b1, 1'b1, 32'h00332211, 8'h33, 2'd2, 1'b1, 1'b0, "d1_scan_ch2"});
        vt.push_back('{1, 2'd3, 1'b1, 1'b1, 32'h00332211, 8'h11, 2'd0, 1'b1, 1'b0, "d1_scan_wrap"});
        vt.push_back('{1, 2'd3, 1'b0, 1'b1, 32'h00332211, 8'h00, 2'd0, 1'b1, 1'b1, "d1_back_to_oor"});

        rst_n = 1'b0;
        data_in = d4; sel = '0; mode = 1'b0; en = 1'b0;
        data3 = 24'h332211; sel3 = '0; mode3 = 1'b0; en3 = 1'b0;

        #12;
        push_exp(0, 8'h00, 2'd0, 1'b0, 1'b0, "reset_state");
        push_exp(1, 8'h00, 2'd0, 1'b0, 1'b0, "reset_state3");
        check_all();

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            sel = 2'd2; mode = i[0];
            push_exp(0, 8'h00, 2'd0, 1'b0, 1'b0, "idle_en0");
            push_exp(1, 8'h00, 2'd0, 1'b0, 1'b0, "idle_en0_3");
            edge_check();
        end

        foreach (vt[i]) begin
            @(negedge clk);
            if (vt[i].which) begin
                en = 1'b0;
                data3 = vt[i].data[23:0]; sel3 = vt[i].sel; mode3 = vt[i].mode; en3 = vt[i].en;
            end else begin
                en3 = 1'b0;
                data_in = vt[i].data; sel = vt[i].sel; mode = vt[i].mode; en = vt[i].en;
            end
            push_exp(vt[i].which, vt[i].m, vt[i].ch, vt[i].valid, vt[i].err, vt[i].tag);
            edge_check();
        end

        // Scan from MANUAL: 20 edges, DWELL=4, then 3 more to reach ch=1 with count 2
        @(negedge clk);
        en3 = 1'b0;
        data_in = d4; sel = 2'd3; mode = 1'b1; en = 1'b1;
        for (int i = 0; i < 23; i++) begin
            ec = 2'((i / 4) % 4);
            push_exp(0, chan(d4, int'(ec)), ec, 1'b1, 1'b0, $sformatf("scan_edge%0d", i));
            edge_check();
        end

        // Freeze with data, mode and sel all changing
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            en = 1'b0; mode = i[0]; sel = 2'(i); data_in = d4b ^ 32'(i);
            push_exp(0, 8'h22, 2'd1, 1'b1, 1'b0, "freeze_hold");
            edge_check();
        end
        @(negedge clk);
        en = 1'b1; mode = 1'b1; data_in = d4b;
        push_exp(0, chan(d4b, 1), 2'd1, 1'b1, 1'b0, "unfreeze_last_ch1");
        edge_check();
        push_exp(0, chan(d4b, 2), 2'd2, 1'b1, 1'b0, "unfreeze_adv_ch2");
        edge_check();

        // Async reset between edges while at ch=2
        #2;
        rst_n = 1'b0;
        #1;
        push_exp(0, 8'h00, 2'd0, 1'b0, 1'b0, "async_reset_mid_scan");
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ec = (i < 4) ? 2'd0 : 2'd1;
            push_exp(0, chan(d4b, int'(ec)), ec, 1'b1, 1'b0, $sformatf("restart_edge%0d", i));
            edge_check();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
